// File: rtl/traceback_unit.sv
// Viterbi survivor-path traceback reader.
// Once the survivor memory reports full or out-of-data, this block walks the
// predecessor-state columns from newest to oldest, starting at the
// best-metric state. Each decoded bit is pushed into a LIFO, and the bits are
// then streamed out oldest-first over a valid/ready handshake.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-low
//   en_tb         block enable; low returns to IDLE (o_tb_err is kept)
//   i_td_full     survivor memory full, starts a traceback
//   i_ood         out of data, starts a traceback
//   i_td_empty    the presented column is the oldest (column 0)
//   i_start_st    best-metric state, sampled at traceback start
//   i_bck_prv_st  predecessor of every state for the presented column
//   i_out_rdy     downstream ready
//   o_dec_bit     decoded bit (oldest first)
//   o_dec_vld     o_dec_bit valid
//   o_dec_last    final bit of the block
//   o_tb_busy     high while tracing
//   o_tb_done     one-cycle pulse after the last bit is accepted
//   o_tb_err      sticky: TB_DEPTH columns consumed without i_td_empty
//   o_bit_cnt     number of bits pushed in the current traceback
module traceback_unit #(
  parameter int unsigned STATE_REG_NUM = 8,
  parameter int unsigned STATE_NUM     = 256,
  parameter int unsigned TB_DEPTH      = 128,
  parameter int unsigned CNT_W         = $clog2(TB_DEPTH) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en_tb,
  input  logic                                     i_td_full,
  input  logic                                     i_ood,
  input  logic                                     i_td_empty,
  input  logic [STATE_REG_NUM-1:0]                 i_start_st,
  input  logic [STATE_NUM-1:0][STATE_REG_NUM-1:0]  i_bck_prv_st,
  input  logic                                     i_out_rdy,
  output logic                                     o_dec_bit,
  output logic                                     o_dec_vld,
  output logic                                     o_dec_last,
  output logic                                     o_tb_busy,
  output logic                                     o_tb_done,
  output logic                                     o_tb_err,
  output logic [CNT_W-1:0]                         o_bit_cnt
);

  localparam int unsigned IDX_W = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TRACE  = 3'd1;
  localparam logic [2:0] S_OUTPUT = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]               state, state_d;
  logic [STATE_REG_NUM-1:0] cur_st, cur_st_d;
  logic [CNT_W-1:0]         ptr, ptr_d;
  logic [CNT_W-1:0]         bit_cnt, bit_cnt_d;
  logic                     tb_err, tb_err_d;
  logic                     push;
  logic [TB_DEPTH-1:0]      lifo;
  logic [IDX_W-1:0]         wr_idx;
  logic [IDX_W-1:0]         rd_idx;
  logic                     dec_vld;

  // LIFO addressing: push at ptr, pop from ptr-1 (top of stack)
  assign wr_idx = IDX_W'(ptr);
  assign rd_idx = IDX_W'(ptr - CNT_W'(1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cur_st  <= '0;
      ptr     <= '0;
      bit_cnt <= '0;
      tb_err  <= 1'b0;
    end else begin
      state   <= state_d;
      cur_st  <= cur_st_d;
      ptr     <= ptr_d;
      bit_cnt <= bit_cnt_d;
      tb_err  <= tb_err_d;
    end
  end

  // Decoded-bit stack
  always_ff @(posedge clk) begin
    if (!rst) begin
      lifo <= '0;
    end else if (push) begin
      lifo[wr_idx] <= cur_st[0];
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state;
    cur_st_d  = cur_st;
    ptr_d     = ptr;
    bit_cnt_d = bit_cnt;
    tb_err_d  = tb_err;
    push      = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_td_full || i_ood) begin
          state_d   = S_TRACE;
          cur_st_d  = i_start_st;
          ptr_d     = '0;
          bit_cnt_d = '0;
          tb_err_d  = 1'b0;
        end
      end

      // One column per cycle; the decoded bit is the LSB of the current state
      S_TRACE: begin
        push      = 1'b1;
        ptr_d     = ptr + CNT_W'(1);
        bit_cnt_d = bit_cnt + CNT_W'(1);
        cur_st_d  = i_bck_prv_st[cur_st];
        if (i_td_empty) begin
          state_d = S_OUTPUT;
        end else if (bit_cnt == CNT_W'(TB_DEPTH - 1)) begin
          // Depth exhausted before reaching column 0
          state_d  = S_OUTPUT;
          tb_err_d = 1'b1;
        end
      end

      S_OUTPUT: begin
        if (i_out_rdy) begin
          ptr_d = ptr - CNT_W'(1);
          if (ptr == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_WAIT;
      end

      // Hold until the memory is handed back (en_tb low); new flags ignored
      S_WAIT: begin
        state_d = S_WAIT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable overrides everything except the sticky error flag
    if (!en_tb) begin
      state_d   = S_IDLE;
      ptr_d     = '0;
      bit_cnt_d = '0;
      tb_err_d  = tb_err;
      push      = 1'b0;
    end
  end

  // Outputs decoded from registered state and LIFO only
  assign dec_vld    = (state == S_OUTPUT);
  assign o_dec_vld  = dec_vld;
  assign o_dec_bit  = dec_vld & lifo[rd_idx];
  assign o_dec_last = dec_vld & (ptr == CNT_W'(1));
  assign o_tb_busy  = (state == S_TRACE);
  assign o_tb_done  = (state == S_DONE);
  assign o_tb_err   = tb_err;
  assign o_bit_cnt  = bit_cnt;

endmodule

// File: tb/tb_traceback_unit.sv
// Scoreboard bench for traceback_unit with a small K=3 survivor-memory model.
module tb_traceback_unit;

  localparam int unsigned SRN = 2;
  localparam int unsigned SN  = 4;
  localparam int unsigned TBD = 8;
  localparam int unsigned CW  = $clog2(TBD) + 1;

  logic                    clk;
  logic                    rst;
  logic                    en_tb;
  logic                    i_td_full;
  logic                    i_ood;
  logic                    i_td_empty;
  logic [SRN-1:0]          i_start_st;
  logic [SN-1:0][SRN-1:0]  i_bck_prv_st;
  logic                    i_out_rdy;
  logic                    o_dec_bit;
  logic                    o_dec_vld;
  logic                    o_dec_last;
  logic                    o_tb_busy;
  logic                    o_tb_done;
  logic                    o_tb_err;
  logic [CW-1:0]           o_bit_cnt;

  traceback_unit #(
    .STATE_REG_NUM(SRN),
    .STATE_NUM    (SN),
    .TB_DEPTH     (TBD),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_tb       (en_tb),
    .i_td_full   (i_td_full),
    .i_ood       (i_ood),
    .i_td_empty  (i_td_empty),
    .i_start_st  (i_start_st),
    .i_bck_prv_st(i_bck_prv_st),
    .i_out_rdy   (i_out_rdy),
    .o_dec_bit   (o_dec_bit),
    .o_dec_vld   (o_dec_vld),
    .o_dec_last  (o_dec_last),
    .o_tb_busy   (o_tb_busy),
    .o_tb_done   (o_tb_done),
    .o_tb_err    (o_tb_err),
    .o_bit_cnt   (o_bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         c0 = 0;
  logic [1:0] path_st[8];
  logic       path_u[8];
  int         path_n = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Encoder model: next = {st[0], u}; bits MSB is the first input
  task automatic load_path(input int n, input logic [7:0] bits);
    logic [1:0] st;
    st = 2'b00;
    for (int k = 0; k < n; k++) begin
      st = {st[0], bits[7-k]};
      path_st[k] = st;
      path_u[k]  = bits[7-k];
    end
    path_n = n;
  endtask

  task automatic expect_bits(input int m);
    for (int k = 0; k < m; k++) begin
      sb.push_back('{b: path_u[k], last: (k == path_n - 1)});
    end
  endtask

  // Survivor column idx: true predecessor for the path state, decoys elsewhere
  task automatic present_col(input int idx, input logic use_empty);
    logic [SN-1:0][SRN-1:0] col;
    logic [1:0]             sv;
    for (int s = 0; s < int'(SN); s++) begin
      sv = 2'(s);
      col[s] = {~sv[0], sv[1]};
      if (sv == path_st[idx]) col[s] = (idx == 0) ? 2'b00 : path_st[idx-1];
    end
    i_bck_prv_st = col;
    i_td_empty   = use_empty && (idx == 0);
  endtask

  task automatic start_run(input logic use_ood);
    @(negedge clk);
    en_tb = 1'b0; i_td_full = 1'b0; i_ood = 1'b0;
    @(negedge clk);
    en_tb      = 1'b1;
    i_td_full  = ~use_ood;
    i_ood      = use_ood;
    i_start_st = path_st[path_n-1];
  endtask

  task automatic feed(input logic use_empty, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      @(negedge clk);
      if (c == 0) begin
        i_td_full = 1'b0; i_ood = 1'b0;
        c0 = cyc;
        check1("busy_in_trace", o_tb_busy, 1'b1);
        check1("err_cleared_on_start", o_tb_err, 1'b0);
      end
      present_col(path_n - 1 - c, use_empty);
    end
  endtask

  task automatic wait_done(input logic alt, input int exp_total);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) i_td_empty = 1'b0;
      i_out_rdy = alt ? (k % 2 == 1) : 1'b1;
      #2;
      if (k == 0) check1("first_vld", o_dec_vld, 1'b1);
      if (o_tb_done) begin
        seen = 1'b1;
        checkn("start_to_done_cycles", cyc - c0 + 1, exp_total);
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: o_tb_done not seen within 64 cycles, required by cycle %0d", exp_total);
    end
    @(negedge clk);
    #2;
    check1("done_one_cycle", o_tb_done, 1'b0);
    check1("no_vld_in_wait", o_dec_vld, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every accepted transfer
  initial begin
    logic held_v;
    logic held_b;
    exp_t e;
    held_v = 1'b0;
    held_b = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (o_dec_vld) begin
        if (held_v) check1("bit_held_while_stalled", o_dec_bit, held_b);
        if (i_out_rdy) begin
          held_v = 1'b0;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got bit %b with empty scoreboard, required no transfer", o_dec_bit);
          end else begin
            e = sb.pop_front();
            check1("dec_bit", o_dec_bit, e.b);
            check1("dec_last", o_dec_last, e.last);
          end
        end else begin
          held_v = 1'b1;
          held_b = o_dec_bit;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check1({tag, "_vld"}, o_dec_vld, 1'b0);
    check1({tag, "_bit"}, o_dec_bit, 1'b0);
    check1({tag, "_last"}, o_dec_last, 1'b0);
    check1({tag, "_busy"}, o_tb_busy, 1'b0);
    check1({tag, "_done"}, o_tb_done, 1'b0);
    checkn({tag, "_bit_cnt"}, int'(o_bit_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en_tb = 1'b0; i_td_full = 1'b0; i_ood = 1'b0;
    i_td_empty = 1'b0; i_out_rdy = 1'b1; i_start_st = '0; i_bck_prv_st = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check1("reset_err", o_tb_err, 1'b0);
    rst = 1'b1;

    // Full at 8 columns, full-rate output
    load_path(8, 8'b10110010);
    checkn("path_start_state", int'(path_st[7]), 2);
    expect_bits(8);
    start_run(1'b0);
    feed(1'b1, 8);
    wait_done(1'b0, 17);
    checkn("s1_bit_cnt", int'(o_bit_cnt), 8);
    check1("s1_err", o_tb_err, 1'b0);

    // Out-of-data after 5 columns
    load_path(5, 8'b11010000);
    expect_bits(5);
    start_run(1'b1);
    feed(1'b1, 5);
    wait_done(1'b0, 11);
    checkn("s2_bit_cnt", int'(o_bit_cnt), 5);
    check1("s2_err", o_tb_err, 1'b0);

    // Alternating ready: 16 output cycles
    load_path(8, 8'b10110010);
    expect_bits(8);
    start_run(1'b0);
    feed(1'b1, 8);
    wait_done(1'b1, 25);
    i_out_rdy = 1'b1;

    // Empty never asserted: depth limit and sticky error
    expect_bits(8);
    start_run(1'b0);
    feed(1'b0, 8);
    wait_done(1'b0, 17);
    check1("s4_err_set", o_tb_err, 1'b1);
    checkn("s4_bit_cnt", int'(o_bit_cnt), 8);
    @(negedge clk); en_tb = 1'b0;
    @(negedge clk);
    check1("s4_err_kept_when_disabled", o_tb_err, 1'b1);

    // Enable dropped in third TRACE cycle, then a clean rerun
    start_run(1'b0);
    feed(1'b1, 2);
    @(negedge clk);
    en_tb = 1'b0;
    present_col(5, 1'b1);
    @(negedge clk);
    check_all_zero("abort");
    expect_bits(8);
    start_run(1'b0);
    feed(1'b1, 8);
    wait_done(1'b0, 17);
    checkn("s5_bit_cnt", int'(o_bit_cnt), 8);

    // Reset after 4 output bits
    expect_bits(4);
    start_run(1'b0);
    feed(1'b1, 8);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) i_td_empty = 1'b0;
      i_out_rdy = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    i_out_rdy = 1'b0;
    @(negedge clk);
    check_all_zero("midout_reset");
    check1("midout_reset_err", o_tb_err, 1'b0);
    checkn("midout_sb_drained", sb.size(), 0);
    rst = 1'b1;
    i_out_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check1("no_vld_after_reset", o_dec_vld, 1'b0);
    end

    checkn("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traceback_unit.md
Name: traceback_unit

Overview:
- Survivor-path reader at the back end of the Viterbi decoder, on the read side of the trellis survivor memory.
- Once the memory reports full (or out-of-data), the block walks the predecessor-state columns from newest to oldest, starting at the best-metric state.
- Each decoded bit is pushed into a LIFO so the walk order is reversed.
- Bits are then streamed out in chronological order over a valid/ready handshake.

Parameters:
- STATE_REG_NUM, 8, bits per state index (`MAX_STATE_REG_NUM).
- STATE_NUM, 256, number of trellis states (`MAX_STATE_NUM).
- TB_DEPTH, 128, maximum columns per traceback and LIFO depth (`TRACEBACK_DEPTH).
- CNT_W, $clog2(TB_DEPTH)+1, width of the bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low
- en_tb  in  1  block enable; low forces IDLE
- i_td_full  in  1  survivor memory full
- i_ood  in  1  out of data: end of stream before full
- i_td_empty  in  1  column currently presented is the oldest (column 0)
- i_start_st  in  STATE_REG_NUM  best-metric state, sampled at traceback start
- i_bck_prv_st  in  STATE_REG_NUM x [STATE_NUM]  predecessor of every state for the presented column
- i_out_rdy  in  1  downstream ready
- o_dec_bit  out  1  decoded bit
- o_dec_vld  out  1  o_dec_bit valid
- o_dec_last  out  1  final bit of the block
- o_tb_busy  out  1  high in TRACE
- o_tb_done  out  1  one-cycle pulse after the last bit is accepted
- o_tb_err  out  1  sticky: TB_DEPTH columns consumed without i_td_empty
- o_bit_cnt  out  CNT_W  number of bits pushed in the current traceback

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; cur_st, LIFO pointer and o_bit_cnt = 0; every output = 0, o_tb_err cleared. Applies from any state, including mid-TRACE or mid-OUTPUT.
- en_tb==0 in any state: next state IDLE; pointer and counter cleared; o_dec_* / o_tb_busy / o_tb_done = 0; o_tb_err is kept.
- Encoder state convention: next_st = {st[STATE_REG_NUM-2:0], u}. The decoded bit for a column is therefore LSB of the current state.
- IDLE: when en_tb && (i_td_full || i_ood), go to TRACE, cur_st <= i_start_st, o_bit_cnt <= 0, o_tb_err <= 0. Both flags high together is identical to either one alone.
- TRACE: column ordering.
  - The column presented in the first TRACE cycle is the newest.
  - Each following cycle presents the next older column.
  - The memory side decrements every enabled cycle; this block consumes one column per cycle and never stalls.
- TRACE: per-cycle action.
  - Push cur_st[0] into LIFO[ptr]; ptr++; o_bit_cnt++.
  - cur_st <= i_bck_prv_st[cur_st].
- TRACE exit:
  - If i_td_empty is high in a cycle, that column is processed and the next state is OUTPUT.
  - If o_bit_cnt reaches TB_DEPTH without i_td_empty, go to OUTPUT and set o_tb_err.
  - Columns are never consumed beyond TB_DEPTH.
- OUTPUT:
  - o_dec_vld=1; o_dec_bit = LIFO[ptr-1], which gives oldest-first order.
  - A transfer occurs when o_dec_vld && i_out_rdy; ptr-- on each transfer.
  - o_dec_bit stays stable while i_out_rdy is low.
  - o_dec_last=1 when ptr==1.
  - Transfer with ptr==1 goes to DONE.
- DONE:
  - o_tb_done=1 for exactly one cycle, then WAIT.
  - o_bit_cnt holds its value until the next start.
- WAIT:
  - Idle until en_tb is deasserted (system hands the memory back to write mode), then IDLE.
  - New full/ood flags are ignored in WAIT.
- Latency:
  - First o_dec_vld: the cycle after the i_td_empty TRACE cycle.
  - Total cycles from the start edge to o_tb_done = N (TRACE) + N (OUTPUT, full rate) + 1.
- Outputs are registered or decoded directly from state plus LIFO; there is no combinational path from i_bck_prv_st to any output.

Test Plan:
Bench config: STATE_REG_NUM=2, STATE_NUM=4, TB_DEPTH=8. The memory model is built from a noiseless K=3 path.
- Inputs 1,0,1,1,0,0,1,0; full asserted, i_start_st=2'b10, i_out_rdy=1 -> o_dec_bit 1,0,1,1,0,0,1,0. o_dec_last on the 8th bit, o_tb_done 1 cycle later, o_bit_cnt=8, done 17 cycles after start.
- i_ood after 5 columns of inputs 1,1,0,1,0; empty on the 5th TRACE cycle -> exactly 5 bits 1,1,0,1,0. o_dec_last on the 5th, o_tb_err=0.
- Scenario 1 with i_out_rdy alternating 0/1 -> same 8 bits, each held stable while rdy=0. OUTPUT lasts 16 cycles.
- i_td_empty never asserted -> TRACE ends after 8 cycles, o_tb_err=1, 8 bits streamed. o_tb_err cleared by the next start.
- en_tb dropped in the 3rd TRACE cycle -> IDLE next cycle, all outputs 0. A fresh full restarts and reproduces the scenario 1 output.
- rst=0 during OUTPUT after 4 bits -> next cycle all outputs 0 and o_bit_cnt=0. No further o_dec_vld until a new full.
